// File: rtl/lu_sched_pkg.sv
// Shared encodings for the logic-unit scheduler: op select codes and FSM states.
package lu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_OR   = 2'b00;
  localparam logic [1:0] OP_XOR  = 2'b01;
  localparam logic [1:0] OP_NOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

endpackage

// File: rtl/lu_core.sv
// Combinational bitwise logic unit shared by both requesters.
module lu_core
  import lu_sched_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] s
);

  always_comb begin
    s = x | y;
    case (op)
      OP_OR:   s = x | y;
      OP_XOR:  s = x ^ y;
      OP_NOR:  s = ~(x | y);
      OP_XNOR: s = ~(x ^ y);
      default: s = x | y;
    endcase
  end

endmodule

// File: rtl/lu_scheduler.sv
// Round-robin scheduler granting two requesters turns on one logic unit (IDLE/EXEC/DONE).
// Optional completed-operation counter port done_cnt is built when LU_SCHED_COUNT_EN is defined.
module lu_scheduler
  import lu_sched_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [1:0]       op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] result,
  output logic             busy
`ifdef LU_SCHED_COUNT_EN
  ,
  output logic [7:0]       done_cnt
`endif
);

  state_t           r_state;
  state_t           w_next;
  logic             r_last;
  logic             r_sel;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_s;
  logic             w_start;
  logic             w_pick1;

  // r_last = 1 means requester 1 was served last, so requester 0 wins a tie.
  assign w_start = (r_state == ST_IDLE) && (req0 || req1);
  assign w_pick1 = req1 && (!req0 || !r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (req0 || req1) w_next = ST_EXEC;
      ST_EXEC: w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != ST_IDLE);
    gnt0 = (r_state == ST_DONE) && !r_sel;
    gnt1 = (r_state == ST_DONE) && r_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last   <= 1'b1;
      r_sel    <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_start)               r_sel    <= w_pick1;
      if (r_state == ST_EXEC)    r_result <= w_s;
      if (r_state == ST_DONE)    r_last   <= r_sel;
    end
  end

  // Operands are pure data: captured once per operation, no reset needed.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_x  <= w_pick1 ? a1  : a0;
      r_y  <= w_pick1 ? b1  : b0;
      r_op <= w_pick1 ? op1 : op0;
    end
  end

  lu_core #(.WIDTH(WIDTH)) u_core (
    .x  (r_x),
    .y  (r_y),
    .op (r_op),
    .s  (w_s)
  );

  assign result = r_result;

`ifdef LU_SCHED_COUNT_EN
  logic [7:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_cnt <= 8'd0;
    else if (r_state == ST_DONE) r_cnt <= r_cnt + 8'd1;
  end

  assign done_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_lu_scheduler.sv
// Directed self-checking bench for lu_scheduler; counter checks build when LU_SCHED_COUNT_EN is defined.
module tb_lu_scheduler;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0, req1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic [1:0]       op0, op1;
  logic             gnt0, gnt1, busy;
  logic [WIDTH-1:0] result;
`ifdef LU_SCHED_COUNT_EN
  logic [7:0]       done_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lu_scheduler #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .a0     (a0),
    .b0     (b0),
    .op0    (op0),
    .req1   (req1),
    .a1     (a1),
    .b1     (b1),
    .op1    (op1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .result (result),
    .busy   (busy)
`ifdef LU_SCHED_COUNT_EN
    ,
    .done_cnt (done_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; op0 = 2'b00;
    a1 = '0; b1 = '0; op1 = 2'b00;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0 = 1'($urandom); req1 = 1'($urandom);
      a0 = 4'($urandom); b0 = 4'($urandom); op0 = 2'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom); op1 = 2'($urandom);
    end
    tick();
    n_tests++; if (result !== 4'b0000) begin n_fail++; $display("FAIL reset_result: got %b expected 0000", result); end
    n_tests++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt0: got %b expected 0", gnt0); end
    n_tests++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL reset_gnt1: got %b expected 0", gnt1); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef LU_SCHED_COUNT_EN
    n_tests++; if (done_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_done_cnt: got %0d expected 0", done_cnt); end
`endif
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Requester 0 alone, OR; operands changed after capture must not matter.
  task automatic test_single();
    @(negedge clk);
    req0 = 1'b1; a0 = 4'b1100; b0 = 4'b1010; op0 = 2'b00;
    tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_exec: got %b expected 1", busy); end
    n_tests++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL single_gnt0_exec: got %b expected 0", gnt0); end
    @(negedge clk);
    a0 = 4'b0000; b0 = 4'b0000; op0 = 2'b11;
    tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_done: got %b expected 1", busy); end
    n_tests++; if (gnt0 !== 1'b1) begin n_fail++; $display("FAIL single_gnt0_done: got %b expected 1", gnt0); end
    n_tests++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL single_gnt1_done: got %b expected 0", gnt1); end
    n_tests++; if (result !== 4'b1110) begin n_fail++; $display("FAIL single_result: got %b expected 1110", result); end
    @(negedge clk);
    req0 = 1'b0;
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b expected 0", busy); end
    n_tests++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL single_gnt0_idle: got %b expected 0", gnt0); end
    n_tests++; if (result !== 4'b1110) begin n_fail++; $display("FAIL single_result_hold: got %b expected 1110", result); end
  endtask

  // Requester 1 alone with NOR: ~(1100 | 1010) = 0001.
  task automatic test_sole_req1();
    @(negedge clk);
    req1 = 1'b1; a1 = 4'b1100; b1 = 4'b1010; op1 = 2'b10;
    tick();
    tick();
    n_tests++; if (gnt1 !== 1'b1) begin n_fail++; $display("FAIL sole1_gnt1: got %b expected 1", gnt1); end
    n_tests++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL sole1_gnt0: got %b expected 0", gnt0); end
    n_tests++; if (result !== 4'b0001) begin n_fail++; $display("FAIL sole1_result: got %b expected 0001", result); end
    @(negedge clk);
    req1 = 1'b0;
    tick();
  endtask

  // Both requesting out of reset: 0 first (XOR 0110), then 1 three cycles later (XNOR 1001).
  task automatic test_tie();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b1; a0 = 4'b1100; b0 = 4'b1010; op0 = 2'b01;
    req1 = 1'b1; a1 = 4'b1100; b1 = 4'b1010; op1 = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_tests++; if (busy !== 1'b1 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL tie_exec: got busy=%b gnt0=%b gnt1=%b expected 1 0 0", busy, gnt0, gnt1); end
    tick();
    n_tests++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL tie_first_gnt: got gnt0=%b gnt1=%b expected 1 0", gnt0, gnt1); end
    n_tests++; if (result !== 4'b0110) begin n_fail++; $display("FAIL tie_first_result: got %b expected 0110", result); end
    tick();
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tie_gap_busy: got %b expected 0", busy); end
    tick();
    n_tests++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL tie_second_exec: got gnt0=%b gnt1=%b expected 0 0", gnt0, gnt1); end
    tick();
    n_tests++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin n_fail++; $display("FAIL tie_second_gnt: got gnt0=%b gnt1=%b expected 0 1", gnt0, gnt1); end
    n_tests++; if (result !== 4'b1001) begin n_fail++; $display("FAIL tie_second_result: got %b expected 1001", result); end
    @(negedge clk);
    idle_inputs();
    tick();
  endtask

  task automatic test_fairness();
    int n_gnt;
    logic seq [4];
    n_gnt = 0;
    for (int i = 0; i < 4; i++) seq[i] = 1'bx;
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b1; a0 = 4'b0011; b0 = 4'b0101; op0 = 2'b00;
    req1 = 1'b1; a1 = 4'b0011; b1 = 4'b0101; op1 = 2'b01;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      n_tests++; if (gnt0 === 1'b1 && gnt1 === 1'b1) begin n_fail++; $display("FAIL fair_overlap: cycle %0d got gnt0=1 gnt1=1 expected at most one", c); end
      if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
        if (n_gnt < 4) seq[n_gnt] = gnt1;
        n_gnt++;
      end
    end
    n_tests++; if (n_gnt !== 4) begin n_fail++; $display("FAIL fair_count: got %0d grants expected 4", n_gnt); end
    n_tests++; if (seq[0] !== 1'b0) begin n_fail++; $display("FAIL fair_seq0: got requester %b expected 0", seq[0]); end
    n_tests++; if (seq[1] !== 1'b1) begin n_fail++; $display("FAIL fair_seq1: got requester %b expected 1", seq[1]); end
    n_tests++; if (seq[2] !== 1'b0) begin n_fail++; $display("FAIL fair_seq2: got requester %b expected 0", seq[2]); end
    n_tests++; if (seq[3] !== 1'b1) begin n_fail++; $display("FAIL fair_seq3: got requester %b expected 1", seq[3]); end
    @(negedge clk);
    idle_inputs();
    tick();
    tick();
  endtask

  // Serve 0 (pointer -> 0), abort 1 in EXEC; reset must restore the pointer so 0 wins the next tie.
  task automatic test_abort();
    logic saw_gnt;
    saw_gnt = 1'b0;
    @(negedge clk);
    req0 = 1'b1; a0 = 4'b1100; b0 = 4'b1010; op0 = 2'b00;
    tick();
    tick();
    n_tests++; if (gnt0 !== 1'b1 || result !== 4'b1110) begin n_fail++; $display("FAIL abort_pre_gnt: got gnt0=%b result=%b expected 1 1110", gnt0, result); end
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b1; a1 = 4'b0011; b1 = 4'b0101; op1 = 2'b01;
    tick();
    tick();
    n_tests++; if (busy !== 1'b1 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL abort_in_exec: got busy=%b gnt1=%b expected 1 0", busy, gnt1); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (result !== 4'b0000 || busy !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL abort_async: got result=%b busy=%b gnt0=%b gnt1=%b expected 0000 0 0 0", result, busy, gnt0, gnt1); end
    for (int c = 0; c < 2; c++) begin
      tick();
      if (gnt1 === 1'b1) saw_gnt = 1'b1;
    end
    @(negedge clk);
    req0 = 1'b1; a0 = 4'b1100; b0 = 4'b1010; op0 = 2'b01;
    req1 = 1'b1; a1 = 4'b1100; b1 = 4'b1010; op1 = 2'b11;
    rst_n = 1'b1;
    tick();
    tick();
    n_tests++; if (saw_gnt !== 1'b0) begin n_fail++; $display("FAIL abort_no_gnt: got gnt1 during reset expected none"); end
    n_tests++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin n_fail++; $display("FAIL abort_next_tie: got gnt0=%b gnt1=%b expected 1 0", gnt0, gnt1); end
    n_tests++; if (result !== 4'b0110) begin n_fail++; $display("FAIL abort_next_result: got %b expected 0110", result); end
    @(negedge clk);
    idle_inputs();
    tick();
  endtask

`ifdef LU_SCHED_COUNT_EN
  task automatic test_counter();
    int n_gnt;
    int cyc;
    n_gnt = 0;
    cyc = 0;
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    req0 = 1'b1; a0 = 4'b1111; b0 = 4'b0000; op0 = 2'b01;
    while (n_gnt < 257 && cyc < 1200) begin
      tick();
      cyc++;
      if (gnt0 === 1'b1) n_gnt++;
    end
    n_tests++; if (n_gnt !== 257) begin n_fail++; $display("FAIL cnt_timeout: got %0d grants expected 257", n_gnt); end
    @(negedge clk);
    req0 = 1'b0;
    tick();
    n_tests++; if (done_cnt !== 8'd1) begin n_fail++; $display("FAIL cnt_wrap: got %0d expected 1", done_cnt); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_sole_req1();
    test_tie();
    test_fairness();
    test_abort();
`ifdef LU_SCHED_COUNT_EN
    test_counter();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
